cmac_acc: RTL and testbench



---
 rtl/cmac_acc.sv | 138 +++++++++++++
 tb/tb_cmac_acc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cmac_acc.sv
// cmac_acc: complex accumulate-and-scale stage behind the complex multiplier.
// Sums len products per lane at full width, then shifts and saturates.
module cmac_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      cfg_len,
  input  logic [4:0]                shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic                      out_sat,
  output logic                      busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = DATA_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic [2*DW-1:0]         out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] re_x, im_x;
  logic signed [ACC_W-1:0] v_r, v_i;
  logic [DW:0]             sr, si;
  logic [LEN_WIDTH-1:0]    len_m1;

  // Result is {sat_flag, lane}; fits when all bits above DW-1 match the sign.
  function automatic logic [DW:0] sat_lane(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DW:0] top;
    logic [DW:0]       res;
    top = v[ACC_W-1:DW-1];
    if ((&top) || !(|top)) begin
      res = {1'b0, v[DW-1:0]};
    end else if (v[ACC_W-1]) begin
      res = {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(DW-1){1'b1}}};
    end
    return res;
  endfunction

  assign re_x   = {{LEN_WIDTH{in_data[2*DW-1]}}, in_data[2*DW-1:DW]};
  assign im_x   = {{LEN_WIDTH{in_data[DW-1]}}, in_data[DW-1:0]};
  assign v_r    = acc_r_q >>> shift_q;
  assign v_i    = acc_i_q >>> shift_q;
  assign sr     = sat_lane(v_r);
  assign si     = sat_lane(v_i);
  assign len_m1 = len_q - LEN_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    acc_r_d    = acc_r_q;
    acc_i_d    = acc_i_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          shift_d = shift;
          acc_r_d = '0;
          acc_i_d = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_r_d = acc_r_q + re_x;
          acc_i_d = acc_i_q + im_x;
          cnt_d   = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == len_m1) state_d = SAT;
        end
      end
      SAT: begin
        out_data_d = {sr[DW-1:0], si[DW-1:0]};
        out_sat_d  = sr[DW] | si[DW];
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_r_q    <= '0;
      acc_i_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_r_q    <= acc_r_d;
      acc_i_q    <= acc_i_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cmac_acc.sv
// tb_cmac_acc: directed checks of cmac_acc sums, shift/saturate,
// backpressure, length wrap and mid-block reset.
module tb_cmac_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic [4:0]  shift;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cmac_acc #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input logic [7:0] len, input logic [4:0] sh);
    start   = 1'b1;
    cfg_len = len;
    shift   = sh;
    cyc();
    start   = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int n;
    int guard;
    logic v;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_len   = '0;
    shift     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", in_ready, 0);

    // basic sum
    start_blk(8'd4, 5'd0);
    chk("basic_in_ready", in_ready, 1);
    chk("basic_busy", busy, 1);
    push(32'h0001_FFFF);
    push(32'h0002_FFFE);
    push(32'h0003_FFFD);
    push(32'h0004_FFFC);
    chk("basic_sat_state_valid", out_valid, 0);
    chk("basic_sat_state_ready", in_ready, 0);
    cyc();
    chk("basic_out_valid", out_valid, 1);
    chk("basic_out_data", out_data, 32'h000A_FFF6);
    chk("basic_out_sat", out_sat, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("basic_drop_valid", out_valid, 0);
    chk("basic_drop_busy", busy, 0);
    chk("basic_hold_data", out_data, 32'h000A_FFF6);

    // saturation, then backpressure with ignored start/in_valid
    start_blk(8'd4, 5'd0);
    for (int k = 0; k < 4; k++) push(32'h7000_9000);
    cyc();
    chk("sat_out_valid", out_valid, 1);
    chk("sat_out_data", out_data, 32'h7FFF_8000);
    chk("sat_out_sat", out_sat, 1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h7FFF_8000);
      chk("bp_sat", out_sat, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    cyc();
    chk("bp_no_new_block", busy, 0);

    // shift, with start and in_valid together in IDLE
    in_valid = 1'b1;
    in_data  = 32'h0003_FFFD;
    start_blk(8'd2, 5'd1);
    in_valid = 1'b0;
    push(32'h0003_FFFD);
    chk("shift_mid_ready", in_ready, 1);
    push(32'h0003_FFFD);
    cyc();
    chk("shift_out_valid", out_valid, 1);
    chk("shift_out_data", out_data, 32'h0003_FFFD);
    chk("shift_out_sat", out_sat, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // length wrap: cfg_len 0 means 256 products
    start_blk(8'd0, 5'd0);
    n = 0;
    guard = 0;
    while (n < 256 && guard < 2000) begin
      v        = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = 32'h0001_0001;
      if (v) chk("wrap_in_ready", in_ready, 1);
      cyc();
      if (v) n++;
      guard++;
    end
    in_valid = 1'b0;
    chk("wrap_count", n, 256);
    chk("wrap_sat_state", out_valid, 0);
    cyc();
    chk("wrap_out_valid", out_valid, 1);
    chk("wrap_out_data", out_data, 32'h0100_0100);
    chk("wrap_out_sat", out_sat, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // reset mid-block
    start_blk(8'd4, 5'd0);
    push(32'h0100_0100);
    push(32'h0100_0100);
    held = out_data;
    chk("pre_rst_data", held, 32'h0100_0100);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_sat", out_sat, 0);
    chk("mrst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    start_blk(8'd1, 5'd0);
    push(32'h0005_0005);
    cyc();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 32'h0005_0005);
    chk("post_rst_sat", out_sat, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("post_rst_drop", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
